// File: rtl/tx_pkg.sv
// Shared definitions for the transmit cyclic-prefix path.
package tx_pkg;

  // Default I/Q sample width, matches the frontend mapper output.
  localparam int TX_DW = 8;

  // Read-side FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_BODY = 2'd2
  } cp_state_e;

  // One complex sample as stored in the block buffer.
  typedef struct packed {
    logic signed [TX_DW-1:0] i;
    logic signed [TX_DW-1:0] q;
  } iq_t;

endpackage

// File: rtl/tx_cp_inserter_if.sv
// Symbol-in / sample-out stream bundle for the cyclic-prefix inserter.
interface tx_cp_inserter_if import tx_pkg::*; #(
  parameter int DW = TX_DW
) ();

  logic                 in_valid;
  logic signed [DW-1:0] in_i;
  logic signed [DW-1:0] in_q;
  logic                 out_valid;
  logic signed [DW-1:0] out_i;
  logic signed [DW-1:0] out_q;
  logic                 out_sof;
  logic                 out_eob;

  // Upstream source / downstream sink side.
  modport master (
    output in_valid, in_i, in_q,
    input  out_valid, out_i, out_q, out_sof, out_eob
  );

  // The inserter itself.
  modport slave (
    input  in_valid, in_i, in_q,
    output out_valid, out_i, out_q, out_sof, out_eob
  );

endinterface

// File: rtl/tx_cp_bank.sv
// Two-bank block buffer: synchronous write, asynchronous read, per-bank full flags.
module tx_cp_bank import tx_pkg::*; #(
  parameter int DW   = TX_DW,
  parameter int NFFT = 16,
  parameter int AW   = $clog2(NFFT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic            wr_bank,
  input  logic [AW-1:0]   wr_addr,
  input  logic [2*DW-1:0] wr_data,
  input  logic            rd_bank,
  input  logic [AW-1:0]   rd_addr,
  output logic [2*DW-1:0] rd_data,
  input  logic [1:0]      full_set,
  input  logic [1:0]      full_clr,
  output logic [1:0]      full
);

  // Bank select is the top address bit, so both banks share one array.
  logic [2*DW-1:0] mem_q [2*NFFT];

  // Store one symbol; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  assign rd_data = mem_q[{rd_bank, rd_addr}];

  // One full flag per bank; set and clear never target the same bank together.
  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    logic flag_q;

    // Track whether this bank holds a complete block awaiting readout.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        flag_q <= 1'b0;
      end else if (full_set[gi]) begin
        flag_q <= 1'b1;
      end else if (full_clr[gi]) begin
        flag_q <= 1'b0;
      end
    end

    assign full[gi] = flag_q;
  end

endmodule

// File: rtl/tx_cp_inserter.sv
// Groups symbols into NFFT blocks and emits each one prefixed by its last CP_LEN samples.
module tx_cp_inserter import tx_pkg::*; #(
  parameter int DW     = TX_DW,
  parameter int NFFT   = 16,
  parameter int CP_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  tx_cp_inserter_if.slave  bus,
  input  logic             ovf_clr,
  output logic             overflow
);

  localparam int AW = $clog2(NFFT);
  localparam logic [AW-1:0] LAST_IDX = AW'(NFFT - 1);
  localparam logic [AW-1:0] CP_START = AW'(NFFT - CP_LEN);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CP   = ST_CP;
  localparam logic [1:0] S_BODY = ST_BODY;

  // Write side
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic          wr_bank_q, wr_bank_d;
  logic          wr_en, drop;
  logic [1:0]    full_set, full_clr, full;

  // Read side
  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic            rd_bank_q, rd_bank_d;
  logic [AW-1:0]   rd_addr;
  logic [2*DW-1:0] rd_data;

  // Output registers
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_i_q, out_i_d;
  logic [DW-1:0] out_q_q, out_q_d;
  logic          out_sof_q, out_sof_d;
  logic          out_eob_q, out_eob_d;
  logic          overflow_q, overflow_d;

  tx_cp_bank #(.DW(DW), .NFFT(NFFT), .AW(AW)) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_bank  (wr_bank_q),
    .wr_addr  (wr_idx_q),
    .wr_data  ({bus.in_i, bus.in_q}),
    .rd_bank  (rd_bank_q),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .full_set (full_set),
    .full_clr (full_clr),
    .full     (full)
  );

  // Accept symbols into the current bank; a full bank drops them and flags overflow.
  always_comb begin
    wr_en     = bus.in_valid && !full[wr_bank_q];
    drop      = bus.in_valid && full[wr_bank_q];
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    full_set  = 2'b00;
    if (wr_en) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d  = '0;
        wr_bank_d = ~wr_bank_q;
        full_set[wr_bank_q] = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Read FSM: IDLE starts a block straight from the prefix; CP also serves a
  // back-to-back block entered at CP_START, where it raises out_sof.
  always_comb begin
    state_d     = state_q;
    rd_idx_d    = rd_idx_q;
    rd_bank_d   = rd_bank_q;
    full_clr    = 2'b00;
    out_valid_d = 1'b0;
    out_i_d     = '0;
    out_q_d     = '0;
    out_sof_d   = 1'b0;
    out_eob_d   = 1'b0;
    rd_addr     = (state_q == S_IDLE) ? CP_START : rd_idx_q;

    case (state_q)
      S_IDLE: begin
        if (full[rd_bank_q]) begin
          out_valid_d          = 1'b1;
          {out_i_d, out_q_d}   = rd_data;
          out_sof_d            = 1'b1;
          rd_idx_d             = CP_START + 1'b1;
          state_d              = (CP_START == LAST_IDX) ? S_BODY : S_CP;
        end
      end
      S_CP: begin
        out_valid_d        = 1'b1;
        {out_i_d, out_q_d} = rd_data;
        out_sof_d          = (rd_idx_q == CP_START);
        rd_idx_d           = rd_idx_q + 1'b1;
        if (rd_idx_q == LAST_IDX) begin
          state_d = S_BODY;
        end
      end
      S_BODY: begin
        out_valid_d        = 1'b1;
        {out_i_d, out_q_d} = rd_data;
        rd_idx_d           = rd_idx_q + 1'b1;
        if (rd_idx_q == LAST_IDX) begin
          out_eob_d           = 1'b1;
          full_clr[rd_bank_q] = 1'b1;
          rd_bank_d           = ~rd_bank_q;
          if (full[~rd_bank_q]) begin
            state_d  = S_CP;
            rd_idx_d = CP_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register pointers, FSM state, outputs and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      state_q     <= S_IDLE;
      rd_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_sof_q   <= 1'b0;
      out_eob_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      rd_bank_q   <= rd_bank_d;
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_sof_q   <= out_sof_d;
      out_eob_q   <= out_eob_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_i     = out_i_q;
  assign bus.out_q     = out_q_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eob   = out_eob_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_tx_cp_inserter.sv
// Scoreboard bench for tx_cp_inserter (NFFT=16, CP_LEN=4, DW=8).
module tb_tx_cp_inserter;

  logic clk = 1'b0;
  logic rst_n;
  logic ovf_clr;
  logic overflow;

  always #5 clk = ~clk;

  tx_cp_inserter_if #(.DW(8)) bus ();

  tx_cp_inserter #(.DW(8), .NFFT(16), .CP_LEN(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ovf_clr  (ovf_clr),
    .overflow (overflow)
  );

  typedef struct packed {
    logic [7:0] i;
    logic [7:0] q;
    logic       sof;
    logic       eob;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] blk_i[$];
  logic [7:0] blk_q[$];
  exp_t       mon_e;
  int         n_tests  = 0;
  int         n_fail   = 0;
  bit         mon_en   = 1'b0;
  int         run_len  = 0;
  int         last_run = 0;
  int         n_sof    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard for every valid sample.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid === 1'b1) begin
        run_len++;
        if (bus.out_sof === 1'b1) n_sof++;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("out_i", {24'd0, bus.out_i}, {24'd0, mon_e.i});
          chk("out_q", {24'd0, bus.out_q}, {24'd0, mon_e.q});
          chk("out_sof", {31'd0, bus.out_sof}, {31'd0, mon_e.sof});
          chk("out_eob", {31'd0, bus.out_eob}, {31'd0, mon_e.eob});
          $display("[TB] out i=%0d q=%0d sof=%0b eob=%0b", bus.out_i, bus.out_q,
                   bus.out_sof, bus.out_eob);
        end
      end else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
        chk("idle_zero", {14'd0, bus.out_sof, bus.out_eob, bus.out_i, bus.out_q}, 32'd0);
      end
    end
  end

  // Model: collect accepted symbols; each full block yields CP + body.
  task automatic model_push(input logic [7:0] i, input logic [7:0] q);
    int idx;
    blk_i.push_back(i);
    blk_q.push_back(q);
    if (blk_i.size() == 16) begin
      for (int j = 0; j < 20; j++) begin
        idx = (j < 4) ? (12 + j) : (j - 4);
        sb.push_back('{i: blk_i[idx], q: blk_q[idx], sof: (j == 0), eob: (j == 19)});
      end
      blk_i.delete();
      blk_q.delete();
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] i, input logic [7:0] q);
    bus.in_valid = v;
    bus.in_i     = i;
    bus.in_q     = q;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] i, input logic [7:0] q, input bit drop);
    if (!drop) model_push(i, q);
    $display("[TB] in  i=%0d q=%0d drop=%0b", $signed(i), $signed(q), drop);
    tick(1'b1, i, q);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'd0, 8'd0);
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((sb.size() != 0 || bus.out_valid === 1'b1) && c < 200) begin
      tick(1'b0, 8'd0, 8'd0);
      c++;
    end
    chk(tag, sb.size(), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    tick(1'b1, 8'h11, 8'h22);
    tick(1'b0, 8'h33, 8'h44);
    chk(tag, {13'd0, bus.out_valid, bus.out_sof, bus.out_eob, bus.out_i, bus.out_q, overflow},
        32'd0);
    sb.delete();
    blk_i.delete();
    blk_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int         cnt;
    int         sof0;
    bit         found;
    logic [15:0] w;
    logic [1:0]  bits;

    rst_n        = 1'b0;
    ovf_clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_i     = '0;
    bus.in_q     = '0;
    @(negedge clk);

    // Reset with in_valid toggling, then a quiet period.
    do_reset("rst_outputs");
    mon_en = 1'b1;
    cnt = 0;
    repeat (40) begin
      tick(1'b0, 8'd0, 8'd0);
      if (bus.out_valid === 1'b1) cnt++;
    end
    chk("idle40_valid", cnt, 32'd0);

    // Single block k=0..15 sampled at e0..e15.
    for (int k = 0; k < 16; k++) send(8'(k), 8'(-k), 1'b0);
    chk("t1_e15_valid", {31'd0, bus.out_valid}, 32'd0);
    idle(1);
    chk("t1_e16_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t1_e16_i", {24'd0, bus.out_i}, 32'd12);
    idle(19);
    chk("t1_e35_eob", {30'd0, bus.out_valid, bus.out_eob}, 32'd3);
    idle(1);
    chk("t1_e36_valid", {31'd0, bus.out_valid}, 32'd0);
    drain("t1_drain");

    // Frontend-paced: four 0xABCD loads of 8 QPSK symbols with gaps.
    sof0 = n_sof;
    w = 16'hABCD;
    for (int ld = 0; ld < 4; ld++) begin
      for (int s = 0; s < 8; s++) begin
        bits = w[15-2*s -: 2];
        send(bits[1] ? 8'(-45 - ld) : 8'(45 + ld), bits[0] ? 8'(-45 - s) : 8'(45 + s), 1'b0);
      end
      idle(4);
    end
    drain("t3_drain");
    chk("t3_blocks", n_sof - sof0, 32'd2);
    chk("t3_overflow", {31'd0, overflow}, 32'd0);

    // Overflow: 48 contiguous symbols; 32..35 dropped; ovf_clr collides with a drop.
    do_reset("t4_rst");
    for (int k = 0; k < 48; k++) begin
      ovf_clr = (k == 33);
      send(8'(k), 8'(k + 64), (k >= 32 && k <= 35));
      ovf_clr = 1'b0;
      if (k == 31) chk("t4_ovf_before", {31'd0, overflow}, 32'd0);
      if (k == 32) chk("t4_ovf_set", {31'd0, overflow}, 32'd1);
      if (k == 33) chk("t6_ovf_clr_vs_drop", {31'd0, overflow}, 32'd1);
    end
    idle(20);
    chk("t4_run_len", last_run, 32'd40);
    for (int k = 48; k < 52; k++) send(8'(k), 8'(k + 64), 1'b0);
    drain("t4_drain");
    chk("t6_ovf_held", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    tick(1'b0, 8'd0, 8'd0);
    ovf_clr = 1'b0;
    chk("t6_ovf_cleared", {31'd0, overflow}, 32'd0);

    // Reset in the middle of the body.
    for (int k = 0; k < 16; k++) send(8'(k), 8'(k + 16), 1'b0);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (bus.out_valid === 1'b1 && bus.out_i === 8'sd5 && bus.out_sof === 1'b0) found = 1'b1;
      else tick(1'b0, 8'd0, 8'd0);
    end
    chk("t5_found_i5", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    tick(1'b0, 8'd0, 8'd0);
    chk("t5_valid_after_rst", {31'd0, bus.out_valid}, 32'd0);
    sb.delete();
    blk_i.delete();
    blk_q.delete();
    rst_n = 1'b1;
    idle(2);
    for (int k = 0; k < 16; k++) send(8'(3 * k + 1), 8'(100 - k), 1'b0);
    drain("t5_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
